// File: rtl/fetch_controller.sv
// fetch_controller: sequential PC generator feeding a circular instruction queue,
// with a redirect that flushes the queue and reloads the fetch PC.
module fetch_controller #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          QUEUE_DEPTH = 2,
  localparam int         AW          = $clog2(QUEUE_DEPTH),
  localparam int         CW          = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_en,
  input  logic          redirect_valid,
  input  logic [63:0]   redirect_pc,
  output logic [63:0]   imem_addr,
  input  logic [31:0]   imem_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [63:0]   out_pc,
  output logic [CW-1:0] q_count
);
  logic [63:0]   r_fetch_pc;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [63:0]   r_pc_q [QUEUE_DEPTH];
  logic [31:0]   r_instr_q [QUEUE_DEPTH];
  logic          w_push;
  logic          w_pop;
  assign imem_addr = r_fetch_pc;
  assign out_valid = r_count != '0;
  assign q_count   = r_count;
  assign out_pc    = r_pc_q[r_head];
  assign out_instr = r_instr_q[r_head];
  assign w_pop     = out_valid & out_ready;
  // A pop frees the slot in the same cycle, so a full queue can still accept a push.
  assign w_push    = fetch_en & ~redirect_valid & ((r_count < CW'(QUEUE_DEPTH)) | w_pop);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc & ~64'h3;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_fetch_pc <= w_push ? r_fetch_pc + 64'd4 : r_fetch_pc;
      r_tail     <= w_push ? r_tail + AW'(1) : r_tail;
      r_head     <= w_pop ? r_head + AW'(1) : r_head;
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_q[r_tail]    <= r_fetch_pc;
      r_instr_q[r_tail] <= imem_instr;
    end
  end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: table-driven vectors on a depth-2 instance plus a
// hand-written wrap/saturation sequence on a depth-4 instance.
module tb_fetch_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, fetch_en, redirect_valid, out_ready, out_valid;
  logic [63:0] redirect_pc, imem_addr, out_pc;
  logic [31:0] imem_instr, out_instr;
  logic [1:0]  q_count;

  logic        w_rst_n, w_fetch_en, w_redirect_valid, w_out_ready, w_out_valid;
  logic [63:0] w_redirect_pc, w_imem_addr, w_out_pc;
  logic [31:0] w_imem_instr, w_out_instr;
  logic [2:0]  w_q_count;

  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [31:0] imem(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h00100093;
      64'h4:   return 32'h00200113;
      64'h8:   return 32'h00308193;
      64'hC:   return 32'h00110213;
      default: return {a[31:2], 2'b11};
    endcase
  endfunction

  assign imem_instr   = imem(imem_addr);
  assign w_imem_instr = imem(w_imem_addr);

  fetch_controller dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .q_count(q_count)
  );

  fetch_controller #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .QUEUE_DEPTH(4)) dut_w (
    .clk(clk), .rst_n(w_rst_n), .fetch_en(w_fetch_en), .redirect_valid(w_redirect_valid),
    .redirect_pc(w_redirect_pc), .imem_addr(w_imem_addr), .imem_instr(w_imem_instr),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_instr(w_out_instr),
    .out_pc(w_out_pc), .q_count(w_q_count)
  );

  typedef struct {
    logic        rst_n, fe, rv;
    logic [63:0] rpc;
    logic        rdy;
    logic        ev;
    logic [1:0]  ec;
    logic [63:0] ea, ep;
    logic [31:0] ei;
  } vec_t;

  vec_t v [28];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    //        rst fe rv rpc     rdy ev cnt addr     head pc  head instr
    v[0]  = '{1, 1, 0, 64'h0,  1,  0, 0, 64'h0,  64'h0,  32'h0};
    v[1]  = '{1, 1, 0, 64'h0,  1,  1, 1, 64'h4,  64'h0,  32'h00100093};
    v[2]  = '{1, 1, 0, 64'h0,  1,  1, 1, 64'h8,  64'h4,  32'h00200113};
    v[3]  = '{1, 1, 0, 64'h0,  1,  1, 1, 64'hC,  64'h8,  32'h00308193};
    v[4]  = '{0, 1, 0, 64'h0,  1,  1, 1, 64'h10, 64'hC,  32'h00110213};
    v[5]  = '{1, 1, 0, 64'h0,  0,  0, 0, 64'h0,  64'h0,  32'h0};
    v[6]  = '{1, 1, 0, 64'h0,  0,  1, 1, 64'h4,  64'h0,  32'h00100093};
    v[7]  = '{1, 1, 0, 64'h0,  0,  1, 2, 64'h8,  64'h0,  32'h00100093};
    v[8]  = '{1, 1, 0, 64'h0,  0,  1, 2, 64'h8,  64'h0,  32'h00100093};
    v[9]  = '{1, 1, 0, 64'h0,  0,  1, 2, 64'h8,  64'h0,  32'h00100093};
    v[10] = '{1, 1, 0, 64'h0,  1,  1, 2, 64'h8,  64'h0,  32'h00100093};
    v[11] = '{1, 1, 0, 64'h0,  1,  1, 2, 64'hC,  64'h4,  32'h00200113};
    v[12] = '{1, 0, 0, 64'h0,  1,  1, 2, 64'h10, 64'h8,  32'h00308193};
    v[13] = '{1, 0, 0, 64'h0,  0,  1, 1, 64'h10, 64'hC,  32'h00110213};
    v[14] = '{1, 1, 0, 64'h0,  0,  1, 1, 64'h10, 64'hC,  32'h00110213};
    v[15] = '{1, 1, 1, 64'h13, 1,  1, 2, 64'h14, 64'hC,  32'h00110213};
    v[16] = '{1, 1, 0, 64'h0,  1,  0, 0, 64'h10, 64'h0,  32'h0};
    v[17] = '{1, 1, 0, 64'h0,  0,  1, 1, 64'h14, 64'h10, 32'h00000013};
    v[18] = '{0, 1, 0, 64'h0,  0,  1, 2, 64'h18, 64'h10, 32'h00000013};
    v[19] = '{1, 0, 0, 64'h0,  1,  0, 0, 64'h0,  64'h0,  32'h0};
    v[20] = '{1, 0, 1, 64'h22, 1,  0, 0, 64'h0,  64'h0,  32'h0};
    v[21] = '{1, 0, 0, 64'h0,  1,  0, 0, 64'h20, 64'h0,  32'h0};
    v[22] = '{1, 1, 0, 64'h0,  1,  0, 0, 64'h20, 64'h0,  32'h0};
    v[23] = '{1, 1, 1, 64'h40, 1,  1, 1, 64'h24, 64'h20, 32'h00000023};
    v[24] = '{1, 1, 0, 64'h0,  1,  0, 0, 64'h40, 64'h0,  32'h0};
    v[25] = '{1, 1, 0, 64'h0,  1,  1, 1, 64'h44, 64'h40, 32'h00000043};
    v[26] = '{0, 1, 1, 64'h80, 1,  1, 1, 64'h48, 64'h44, 32'h00000047};
    v[27] = '{1, 0, 0, 64'h0,  1,  0, 0, 64'h0,  64'h0,  32'h0};

    rst_n = 0; fetch_en = 0; redirect_valid = 0; redirect_pc = '0; out_ready = 0;
    w_rst_n = 0; w_fetch_en = 0; w_redirect_valid = 0; w_redirect_pc = '0; w_out_ready = 0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      rst_n = v[i].rst_n; fetch_en = v[i].fe; redirect_valid = v[i].rv;
      redirect_pc = v[i].rpc; out_ready = v[i].rdy;
      #1;
      chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(v[i].ev));
      chk($sformatf("v%0d q_count", i), 64'(q_count), 64'(v[i].ec));
      chk($sformatf("v%0d imem_addr", i), imem_addr, v[i].ea);
      if (v[i].ev) begin
        chk($sformatf("v%0d out_pc", i), out_pc, v[i].ep);
        chk($sformatf("v%0d out_instr", i), 64'(out_instr), 64'(v[i].ei));
      end
    end

    @(negedge clk);
    w_rst_n = 1; w_fetch_en = 1; w_out_ready = 0;
    #1;
    chk("wrap reset q_count", 64'(w_q_count), 64'd0);
    chk("wrap reset imem_addr", w_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap reset out_valid", 64'(w_out_valid), 64'd0);
    repeat (6) @(negedge clk);
    #1;
    chk("wrap saturated q_count", 64'(w_q_count), 64'd4);
    chk("wrap held imem_addr", w_imem_addr, 64'hC);
    chk("wrap held out_pc", w_out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    w_out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      logic [63:0] e;
      e = 64'hFFFF_FFFF_FFFF_FFFC + 64'(4 * i);
      #1;
      chk($sformatf("wrap d%0d out_pc", i), w_out_pc, e);
      chk($sformatf("wrap d%0d out_instr", i), 64'(w_out_instr), 64'(imem(e)));
      chk($sformatf("wrap d%0d q_count", i), 64'(w_q_count), 64'd4);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The module SHALL take parameter RESET_PC, default 64'h0, meaning the fetch address loaded on reset.
REQ-002 The module SHALL take parameter QUEUE_DEPTH, default 2, meaning the instruction queue entries; legal values are 2 and 4 only.
REQ-003 The module SHALL have port clk, input, 1, meaning the single clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1, meaning a synchronous, active-low reset.
REQ-005 The module SHALL have port fetch_en, input, 1, meaning that fetching is allowed when 1.
REQ-006 The module SHALL have port redirect_valid, input, 1, meaning a PC redirect request.
REQ-007 The module SHALL have port redirect_pc, input, DATA_WIDTH (64), meaning the redirect target.
REQ-008 The module SHALL have port imem_addr, output, DATA_WIDTH, meaning the address to the combinational instruction memory.
REQ-009 The module SHALL have port imem_instr, input, INSTR_WIDTH (32), meaning the instruction returned for imem_addr in the same cycle.
REQ-010 The module SHALL have port out_valid, output, 1, meaning the queue head is valid.
REQ-011 The module SHALL have port out_ready, input, 1, meaning the consumer accepts the head.
REQ-012 The module SHALL have port out_instr, output, INSTR_WIDTH, meaning the head instruction.
REQ-013 The module SHALL have port out_pc, output, DATA_WIDTH, meaning the head PC.
REQ-014 The module SHALL have port q_count, output, clog2(QUEUE_DEPTH)+1, meaning the occupied entries.

Function
REQ-015 fetch_pc register; imem_addr SHALL equal fetch_pc combinationally at all times.
REQ-016 push = fetch_en & !redirect_valid & (count < QUEUE_DEPTH | pop).
REQ-017 pop = out_valid & out_ready.
REQ-018 On push: {fetch_pc, imem_instr} is written at the tail, and fetch_pc <= fetch_pc + 4, modulo 2^64 (wraps to 0).
REQ-019 On no push and no redirect: fetch_pc holds.
REQ-020 Latency: an entry pushed at edge N SHALL be visible at the head (out_valid = 1) in the cycle after edge N, when the queue was empty.
REQ-021 The queue SHALL be FIFO, circular head/tail pointers, with wrap-around at QUEUE_DEPTH.
REQ-022 out_valid SHALL equal (count != 0).
REQ-023 out_instr/out_pc SHALL equal the head entry and SHALL be stable while out_valid & !out_ready.
REQ-024 Full with pop in the same cycle: push and pop both occur, and count is unchanged.
REQ-025 Empty: no pop; a push alone increments count.
REQ-026 Redirect (highest priority): all entries SHALL be flushed (count <= 0, pointers reset), fetch_pc <= {redirect_pc[63:2], 2'b00}, and no push.
REQ-027 A pop in the redirect cycle is a completed handshake; the flushed entries are not re-presented.
REQ-028 fetch_en = 0: no push; pops continue and the queue drains.
REQ-029 Redirect while fetch_en = 0 SHALL still flush and load fetch_pc.
REQ-030 q_count SHALL equal the count register and SHALL never exceed QUEUE_DEPTH.

Reset
REQ-031 When rst_n = 0 at an edge: fetch_pc <= RESET_PC, count <= 0, and pointers <= 0.
REQ-032 Reset SHALL override redirect, push and pop.
REQ-033 Output values after reset: out_valid = 0, q_count = 0, imem_addr = RESET_PC; out_instr/out_pc are don't-care while out_valid = 0.
REQ-034 Reset asserted mid-operation SHALL discard all queued entries at that edge.

Verification
REQ-035 Start-up: RESET_PC = 0, memory holding 0x00100093, 0x00200113, 0x00308193, 0x00110213 at words 0-3, fetch_en = 1, out_ready = 1, release rst_n -> from the next cycle onward, out_pc = 0, 4, 8, 0xC with those four instructions on consecutive cycles.
REQ-036 Backpressure: out_ready = 0 for 5 cycles from start-up -> q_count saturates at 2, imem_addr holds at 8, and out_pc holds at 0; then out_ready = 1 -> pc 0, 4, 8 delivered in order with no loss or duplication.
REQ-037 Redirect: redirect_valid = 1 with redirect_pc = 0x13 while 2 entries are queued -> next cycle out_valid = 0, q_count = 0, imem_addr = 0x10; the cycle after, out_pc = 0x10 and out_instr = 0x00000013.
REQ-038 Wrap: RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC -> the second delivered out_pc = 0.
REQ-039 Mid-run reset: rst_n = 0 for 1 cycle with q_count = 2 -> next cycle out_valid = 0, q_count = 0, imem_addr = RESET_PC.
REQ-040 Full with simultaneous pop (QUEUE_DEPTH = 2, out_ready toggled) -> q_count stays at 2 on push+pop cycles, and PC order is strictly +4.
